usb_rx_data_pkt: RTL and testbench

- Receive-side counterpart of the team's USB transmit FSM; sits between the UTMI-style receive interface and the endpoint buffer logic.
- Takes the byte stream of one USB packet and checks the PID.
- Forwards data-packet payload bytes with the two trailing CRC bytes stripped.
- Checks CRC16 over payload plus CRC and reports a per-packet status pulse.

---
 rtl/usb_rx_data_pkt.sv | 200 ++++++++++++++++++++
 tb/tb_usb_rx_data_pkt.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_data_pkt.sv
// USB receive data-packet engine: checks the PID and forwards the payload with the two CRC
// bytes removed. It also checks the CRC16 residual and issues one status pulse per packet.
module usb_rx_data_pkt #(
  parameter int unsigned MAX_PAYLOAD = 1023,
  parameter int unsigned CNT_W       = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_active,
  input  logic             rx_valid,
  input  logic             rx_error,
  input  logic [7:0]       rx_data,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic [3:0]       pid_out,
  output logic [CNT_W-1:0] byte_count,
  output logic             pkt_done,
  output logic             crc_ok,
  output logic             pid_err,
  output logic             crc_err
);

  typedef enum logic [2:0] {StIdle, StPid, StData, StDrain, StDone} state_e;

  state_e      state_q;
  logic [15:0] crc_q;
  logic [7:0]  hold0_q;     // newest held byte
  logic [7:0]  hold1_q;     // oldest held byte, next to be evicted
  logic [1:0]  hold_cnt_q;  // bytes in the hold register, saturates at 2
  logic        init_q;      // high only in the first cycle after reset release
  logic        quiet_q;     // draining a packet cut by reset: finish without a status pulse

  // Reflected CRC16 (poly A001) over one byte, bit 0 first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  logic [15:0] crc_next;
  logic [15:0] crc_end;
  logic [1:0]  hold_cnt_next;
  logic [1:0]  cnt_end;
  logic        pid_valid;
  logic        evict;
  logic        overflow;
  logic        end_good;

  // Decode of the incoming byte and the end-of-packet verdict.
  always_comb begin
    crc_next      = crc16_byte(crc_q, rx_data);
    // DATA0/1/2/MDATA are exactly the PIDs whose two low bits are 11.
    pid_valid     = (rx_data[7:4] == ~rx_data[3:0]) && (rx_data[1:0] == 2'b11);
    evict         = (hold_cnt_q == 2'd2);
    hold_cnt_next = evict ? 2'd2 : hold_cnt_q + 2'd1;
    overflow      = evict && (byte_count == CNT_W'(MAX_PAYLOAD));
    // A byte arriving with the rx_active fall is accepted before the packet is closed.
    crc_end       = rx_valid ? crc_next : crc_q;
    cnt_end       = rx_valid ? hold_cnt_next : hold_cnt_q;
    end_good      = (crc_end == 16'hB001) && (cnt_end == 2'd2);
  end

  // Packet FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      crc_q      <= 16'hFFFF;
      hold0_q    <= 8'h00;
      hold1_q    <= 8'h00;
      hold_cnt_q <= 2'd0;
      init_q     <= 1'b1;
      quiet_q    <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      pid_out    <= 4'h0;
      byte_count <= '0;
      pkt_done   <= 1'b0;
      crc_ok     <= 1'b0;
      pid_err    <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      init_q     <= 1'b0;
      data_valid <= 1'b0;
      pkt_done   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          crc_q      <= 16'hFFFF;
          hold0_q    <= 8'h00;
          hold1_q    <= 8'h00;
          hold_cnt_q <= 2'd0;
          if (rx_active) begin
            if (init_q) begin
              // Reset landed mid-packet: swallow the remainder silently.
              quiet_q <= 1'b1;
              state_q <= StDrain;
            end else begin
              state_q <= StPid;
            end
          end
        end

        StPid: begin
          if (rx_error) begin
            byte_count <= '0;
            crc_ok     <= 1'b0;
            pid_err    <= 1'b0;
            crc_err    <= 1'b1;
            state_q    <= StDrain;
          end else if (rx_valid) begin
            pid_out    <= rx_data[3:0];
            byte_count <= '0;
            crc_ok     <= 1'b0;
            if (!pid_valid) begin
              pid_err  <= 1'b1;
              crc_err  <= 1'b0;
              state_q  <= rx_active ? StDrain : StDone;
              pkt_done <= !rx_active;
            end else if (!rx_active) begin
              // Good PID but no data bytes at all.
              pid_err  <= 1'b0;
              crc_err  <= 1'b1;
              state_q  <= StDone;
              pkt_done <= 1'b1;
            end else begin
              pid_err  <= 1'b0;
              crc_err  <= 1'b0;
              state_q  <= StData;
            end
          end else if (!rx_active) begin
            byte_count <= '0;
            crc_ok     <= 1'b0;
            pid_err    <= 1'b1;
            crc_err    <= 1'b0;
            state_q    <= StDone;
            pkt_done   <= 1'b1;
          end
        end

        StData: begin
          if (rx_error) begin
            crc_ok  <= 1'b0;
            crc_err <= 1'b1;
            state_q <= StDrain;
          end else begin
            if (rx_valid) begin
              if (overflow) begin
                crc_ok  <= 1'b0;
                crc_err <= 1'b1;
                state_q <= StDrain;
              end else begin
                crc_q      <= crc_next;
                hold0_q    <= rx_data;
                hold1_q    <= hold0_q;
                hold_cnt_q <= hold_cnt_next;
                if (evict) begin
                  data_out   <= hold1_q;
                  data_valid <= 1'b1;
                  byte_count <= byte_count + CNT_W'(1);
                end
              end
            end
            if (!rx_active && !(rx_valid && overflow)) begin
              crc_ok   <= end_good;
              crc_err  <= !end_good;
              state_q  <= StDone;
              pkt_done <= 1'b1;
            end
          end
        end

        StDrain: begin
          if (!rx_active) begin
            if (quiet_q) begin
              quiet_q <= 1'b0;
              state_q <= StIdle;
            end else begin
              state_q  <= StDone;
              pkt_done <= 1'b1;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_data_pkt.sv
// Scoreboard bench for usb_rx_data_pkt: directed packets push hand-derived expectations,
// a negedge monitor pops and compares on every data_valid and pkt_done.
module tb_usb_rx_data_pkt;

  localparam int unsigned MaxPayload = 4;
  localparam int unsigned CntW       = 11;

  logic            clk       = 1'b0;
  logic            reset     = 1'b0;
  logic            rx_active = 1'b0;
  logic            rx_valid  = 1'b0;
  logic            rx_error  = 1'b0;
  logic [7:0]      rx_data   = 8'h00;
  logic [7:0]      data_out;
  logic            data_valid;
  logic [3:0]      pid_out;
  logic [CntW-1:0] byte_count;
  logic            pkt_done;
  logic            crc_ok;
  logic            pid_err;
  logic            crc_err;

  usb_rx_data_pkt #(
    .MAX_PAYLOAD(MaxPayload),
    .CNT_W      (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_active (rx_active),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .rx_data   (rx_data),
    .data_out  (data_out),
    .data_valid(data_valid),
    .pid_out   (pid_out),
    .byte_count(byte_count),
    .pkt_done  (pkt_done),
    .crc_ok    (crc_ok),
    .pid_err   (pid_err),
    .crc_err   (crc_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      pid;
    logic [CntW-1:0] cnt;
    logic [2:0]      flags;  // {crc_ok, pid_err, crc_err}
  } stat_t;

  logic [7:0] exp_data[$];
  stat_t      exp_stat[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] pkt[0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic push_stat(input logic [3:0] pid, input int cnt, input logic ok,
                           input logic pe, input logic ce);
    stat_t s;
    s.pid   = pid;
    s.cnt   = CntW'(cnt);
    s.flags = {ok, pe, ce};
    exp_stat.push_back(s);
  endtask

  // Appends the complemented CRC16 of pkt[1..len-1], low byte first; returns new length.
  function automatic int add_crc(input int len);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 1; i < len; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pkt[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    c = ~c;
    pkt[len]     = c[7:0];
    pkt[len + 1] = c[15:8];
    return len + 2;
  endfunction

  // Sends pkt[0..n-1]; rx_error rides on byte err_at; optionally drops rx_active with the last.
  task automatic send_pkt(input int n, input int err_at, input bit fall_with_last);
    @(posedge clk); #1 rx_active = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = pkt[i];
      rx_error = (i == err_at);
      if (fall_with_last && (i == n - 1)) rx_active = 1'b0;
    end
    @(posedge clk); #1;
    rx_valid  = 1'b0;
    rx_error  = 1'b0;
    rx_active = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Monitor: compare every output event against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      if (data_valid) begin
        check("data_valid expected", 32'(exp_data.size() != 0), 32'd1);
        if (exp_data.size() != 0) check("data_out", 32'(data_out), 32'(exp_data.pop_front()));
      end
      if (pkt_done) begin
        check("pkt_done expected", 32'(exp_stat.size() != 0), 32'd1);
        if (exp_stat.size() != 0) begin
          stat_t s;
          s = exp_stat.pop_front();
          check("pid_out", 32'(pid_out), 32'(s.pid));
          check("byte_count", 32'(byte_count), 32'(s.cnt));
          check("status {crc_ok,pid_err,crc_err}", 32'({crc_ok, pid_err, crc_err}),
                32'(s.flags));
        end
      end
    end
  end

  int n;

  initial begin
    #12;
    check("outputs at reset", 32'({data_out, data_valid, pid_out, byte_count, pkt_done,
                                   crc_ok, pid_err, crc_err}), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Empty DATA0.
    pkt[0] = 8'hC3; pkt[1] = 8'h00; pkt[2] = 8'h00;
    push_stat(4'h3, 0, 1'b1, 1'b0, 1'b0);
    send_pkt(3, -1, 1'b0);

    // DATA1 with three payload bytes.
    pkt[0] = 8'h4B; pkt[1] = 8'h01; pkt[2] = 8'h02; pkt[3] = 8'h03;
    n = add_crc(4);
    exp_data.push_back(8'h01); exp_data.push_back(8'h02); exp_data.push_back(8'h03);
    push_stat(4'hB, 3, 1'b1, 1'b0, 1'b0);
    send_pkt(n, -1, 1'b0);

    // Corrupted CRC.
    pkt[0] = 8'hC3; pkt[1] = 8'h00; pkt[2] = 8'h01;
    push_stat(4'h3, 0, 1'b0, 1'b0, 1'b1);
    send_pkt(3, -1, 1'b0);

    // Short packet: one data byte only.
    pkt[0] = 8'hC3; pkt[1] = 8'h00;
    push_stat(4'h3, 0, 1'b0, 1'b0, 1'b1);
    send_pkt(2, -1, 1'b0);

    // PID check nibble wrong.
    pkt[0] = 8'hC2; pkt[1] = 8'h00; pkt[2] = 8'h00;
    push_stat(4'h2, 0, 1'b0, 1'b1, 1'b0);
    send_pkt(3, -1, 1'b0);

    // Well-formed ACK is not a data PID.
    pkt[0] = 8'hD2;
    push_stat(4'h2, 0, 1'b0, 1'b1, 1'b0);
    send_pkt(1, -1, 1'b0);

    // rx_error on the third data byte: nothing delivered.
    pkt[0] = 8'hC3; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h44;
    n = add_crc(5);
    push_stat(4'h3, 0, 1'b0, 1'b0, 1'b1);
    send_pkt(n, 3, 1'b0);

    // Overflow: six payload bytes against a limit of four.
    pkt[0] = 8'hC3;
    for (int i = 1; i <= 6; i++) pkt[i] = 8'(i);
    n = add_crc(7);
    for (int i = 1; i <= 4; i++) exp_data.push_back(8'(i));
    push_stat(4'h3, 4, 1'b0, 1'b0, 1'b1);
    send_pkt(n, -1, 1'b0);

    // DATA2 with rx_active falling together with the last CRC byte.
    pkt[0] = 8'h87; pkt[1] = 8'hAA; pkt[2] = 8'h55;
    n = add_crc(3);
    exp_data.push_back(8'hAA); exp_data.push_back(8'h55);
    push_stat(4'h7, 2, 1'b1, 1'b0, 1'b0);
    send_pkt(n, -1, 1'b1);

    // MDATA with a single payload byte at the limit-free end.
    pkt[0] = 8'h0F; pkt[1] = 8'h5A;
    n = add_crc(2);
    exp_data.push_back(8'h5A);
    push_stat(4'hF, 1, 1'b1, 1'b0, 1'b0);
    send_pkt(n, -1, 1'b0);

    // rx_active pulse with no byte: pid_out keeps the previous PID.
    push_stat(4'hF, 0, 1'b0, 1'b1, 1'b0);
    send_pkt(0, -1, 1'b0);

    // Reset in the middle of a payload.
    pkt[0] = 8'hC3; pkt[1] = 8'hAA; pkt[2] = 8'hBB; pkt[3] = 8'hCC;
    exp_data.push_back(8'hAA);
    @(posedge clk); #1 rx_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = pkt[i];
    end
    @(posedge clk); #1 rx_valid = 1'b0;
    @(negedge clk); #2 reset = 1'b0;
    #1;
    check("outputs during mid-packet reset", 32'({data_out, data_valid, pid_out, byte_count,
                                                  pkt_done, crc_ok, pid_err, crc_err}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'hE0 + 8'(i);
    end
    @(posedge clk); #1;
    rx_valid  = 1'b0;
    rx_active = 1'b0;
    repeat (4) @(posedge clk);

    // Normal reception after the reset.
    pkt[0] = 8'h4B; pkt[1] = 8'h01; pkt[2] = 8'h02; pkt[3] = 8'h03;
    n = add_crc(4);
    exp_data.push_back(8'h01); exp_data.push_back(8'h02); exp_data.push_back(8'h03);
    push_stat(4'hB, 3, 1'b1, 1'b0, 1'b0);
    send_pkt(n, -1, 1'b0);

    repeat (4) @(posedge clk);
    check("data events missing", 32'(exp_data.size()), 32'd0);
    check("pkt_done events missing", 32'(exp_stat.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
